// File: rtl/router_1x3.sv
// router_1x3: one byte-serial source port steered into three destination FIFOs.
// The header byte selects the FIFO (address 3 is dropped), packet parity is
// checked and reported on err, and each FIFO drains through valid/read_enb.
// Optional feature: define ROUTER_SOFT_RESET_EN to flush a destination FIFO
// that has sat unread for SOFT_RST_CYCLES cycles.
module router_1x3 #(
  parameter int FIFO_DEPTH      = 16,
  parameter int SOFT_RST_CYCLES = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] data_in,
  input  logic       pkt_valid,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       valid_out_2,
  output logic       busy,
  output logic       err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (SOFT_RST_CYCLES < 1) begin : g_chk_soft
    $error("SOFT_RST_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_DATA,
    CHECK_PARITY,
    DROP
  } state_t;

  state_t     r_state;
  logic [1:0] r_addr;
  logic [7:0] r_hdr;
  logic [7:0] r_parity;
  logic [7:0] r_rx_parity;
  logic       r_err;

  logic [2:0] w_empty;
  logic [2:0] w_full;
  logic [2:0] w_rd_req;
  logic [7:0] w_dout [3];

  logic       w_wr_go;
  logic [1:0] w_wr_addr;
  logic [7:0] w_wr_data;
  logic       w_busy;

  assign w_rd_req = {read_enb_2, read_enb_1, read_enb_0};

  // Select one of the three per-port flags by address; address 3 selects none.
  function automatic logic pick(input logic [2:0] v, input logic [1:0] a);
    case (a)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  // Write request and source back-pressure, decoded from state and FIFO flags.
  always_comb begin
    w_wr_go   = 1'b0;
    w_wr_addr = r_addr;
    w_wr_data = data_in;
    w_busy    = 1'b0;
    case (r_state)
      DECODE_ADDRESS: begin
        w_wr_addr = data_in[1:0];
        w_wr_go   = pkt_valid && (data_in[1:0] != 2'd3) && pick(w_empty, data_in[1:0]);
      end
      WAIT_TILL_EMPTY: begin
        w_busy    = 1'b1;
        w_wr_data = r_hdr;
        w_wr_go   = pick(w_empty, r_addr);
      end
      LOAD_DATA: begin
        w_busy  = pick(w_full, r_addr);
        w_wr_go = !pick(w_full, r_addr);
      end
      CHECK_PARITY: begin
        w_busy = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Packet FSM: header decode, payload load, parity check and drop handling.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= DECODE_ADDRESS;
      r_addr      <= '0;
      r_hdr       <= '0;
      r_parity    <= '0;
      r_rx_parity <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            r_hdr    <= data_in;
            r_addr   <= data_in[1:0];
            r_parity <= data_in;
            r_err    <= 1'b0;
            if (data_in[1:0] == 2'd3) begin
              r_state <= DROP;
            end else if (pick(w_empty, data_in[1:0])) begin
              r_state <= LOAD_DATA;
            end else begin
              r_state <= WAIT_TILL_EMPTY;
            end
          end
        end
        WAIT_TILL_EMPTY: begin
          if (pick(w_empty, r_addr)) begin
            r_state <= LOAD_DATA;
          end
        end
        LOAD_DATA: begin
          if (!pick(w_full, r_addr)) begin
            if (pkt_valid) begin
              r_parity <= r_parity ^ data_in;
            end else begin
              r_rx_parity <= data_in;
              r_state     <= CHECK_PARITY;
            end
          end
        end
        CHECK_PARITY: begin
          r_err   <= (r_parity != r_rx_parity);
          r_state <= DECODE_ADDRESS;
        end
        DROP: begin
          r_err <= 1'b0;
          if (!pkt_valid) begin
            r_state <= DECODE_ADDRESS;
          end
        end
        default: begin
          r_state <= DECODE_ADDRESS;
        end
      endcase
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_dout;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_flush;

    assign w_empty[g] = (r_count == '0);
    assign w_full[g]  = (r_count == CW'(FIFO_DEPTH));
    assign w_wr_en    = w_wr_go && (w_wr_addr == 2'(g));
    assign w_rd_en    = w_rd_req[g] && !w_empty[g];
    assign w_dout[g]  = r_dout;

`ifdef ROUTER_SOFT_RESET_EN
    localparam int IW = $clog2(SOFT_RST_CYCLES + 1);
    logic [IW-1:0] r_idle;

    assign w_flush = !w_empty[g] && !w_rd_req[g] && (r_idle == IW'(SOFT_RST_CYCLES - 1));

    // Count cycles that the head byte sits unread; any read or empty FIFO restarts it.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_idle <= '0;
      end else if (w_empty[g] || w_rd_req[g] || w_flush) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + IW'(1);
      end
    end
`else
    assign w_flush = 1'b0;
`endif

    // Storage array; written whenever the FSM targets this port and it is not full.
    always_ff @(posedge clk) begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= w_wr_data;
      end
    end

    // Pointers, occupancy and registered head byte.
    // A flush discards everything already stored but keeps a same-cycle write,
    // so the FSM can continue loading the packet into the emptied FIFO.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_dout   <= '0;
      end else if (w_flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_wr_ptr <= r_wr_ptr + AW'(w_wr_en);
        r_count  <= CW'(w_wr_en);
      end else begin
        if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_rd_en) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
          r_dout   <= r_mem[r_rd_ptr];
        end
        r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
      end
    end
  end

  assign data_out_0  = w_dout[0];
  assign data_out_1  = w_dout[1];
  assign data_out_2  = w_dout[2];
  assign valid_out_0 = !w_empty[0];
  assign valid_out_1 = !w_empty[1];
  assign valid_out_2 = !w_empty[2];
  assign busy        = w_busy;
  assign err         = r_err;

endmodule

// File: tb/tb_router_1x3.sv
// Directed bench for router_1x3: reset, good/bad parity, full FIFO,
// busy-wait on a non-empty port, address-3 drop, idle timeout, mid-packet reset.
module tb_router_1x3;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       valid_out_0, valid_out_1, valid_out_2;
  logic       busy;
  logic       err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  router_1x3 #(.FIFO_DEPTH(16), .SOFT_RST_CYCLES(30)) dut (
    .clk(clk), .resetn(resetn), .data_in(data_in), .pkt_valid(pkt_valid),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic vout(input int p);
    case (p)
      0:       return valid_out_0;
      1:       return valid_out_1;
      default: return valid_out_2;
    endcase
  endfunction

  function automatic logic [7:0] dout(input int p);
    case (p)
      0:       return data_out_0;
      1:       return data_out_1;
      default: return data_out_2;
    endcase
  endfunction

  task automatic set_rd(input int p, input logic v);
    case (p)
      0:       read_enb_0 = v;
      1:       read_enb_1 = v;
      default: read_enb_2 = v;
    endcase
  endtask

  // Present one byte and hold it until it is taken (busy low before an edge).
  task automatic send_byte(input logic [7:0] d, input logic v);
    bit ok = 0;
    data_in   = d;
    pkt_valid = v;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (!busy) ok = 1;
      tick();
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: byte %h still not accepted, required acceptance", d);
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl[$], input logic [7:0] par);
    send_byte(hdr, 1'b1);
    foreach (pl[i]) send_byte(pl[i], 1'b1);
    send_byte(par, 1'b0);
    data_in = 8'h00;
  endtask

  // Hold read_enb on port p until n bytes have been popped (bounded).
  task automatic pop_n(input int p, input int n, output logic [7:0] q[$]);
    q = {};
    set_rd(p, 1'b1);
    for (int i = 0; i < 300 && q.size() < n; i++) begin
      logic v;
      v = vout(p);
      tick();
      if (v) q.push_back(dout(p));
    end
    set_rd(p, 1'b0);
  endtask

  task automatic test_reset();
    resetn = 1'b0; data_in = 8'h00; pkt_valid = 1'b0;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    #2;
    n_checks++; if ({valid_out_0, valid_out_1, valid_out_2} !== 3'b000) $display("FAIL rst_valid: got %b required 000", {valid_out_0, valid_out_1, valid_out_2}); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b required 0", err); else n_pass++;
    n_checks++; if ({data_out_0, data_out_1, data_out_2} !== 24'h0) $display("FAIL rst_data: got %h required 000000", {data_out_0, data_out_1, data_out_2}); else n_pass++;
    tick(); tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_good_packet();
    logic [7:0] q[$];
    logic [7:0] par;
    logic [7:0] exp[$];
    par = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
    exp = '{8'h0D, 8'h11, 8'h22, 8'h33, par};
    send_pkt(8'h0D, '{8'h11, 8'h22, 8'h33}, par);
    n_checks++; if (busy !== 1'b1) $display("FAIL good_check_busy: got %b required 1", busy); else n_pass++;
    tick();
    n_checks++; if (err !== 1'b0) $display("FAIL good_err: got %b required 0", err); else n_pass++;
    n_checks++; if ({valid_out_0, valid_out_1, valid_out_2} !== 3'b010) $display("FAIL good_valid: got %b required 010", {valid_out_0, valid_out_1, valid_out_2}); else n_pass++;
    pop_n(1, 5, q);
    n_checks++; if (q.size() != 5) $display("FAIL good_count: got %0d required 5", q.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= q.size()) $display("FAIL good_byte%0d: got none required %h", i, exp[i]);
      else if (q[i] !== exp[i]) $display("FAIL good_byte%0d: got %h required %h", i, q[i], exp[i]);
      else n_pass++;
    end
    n_checks++; if (valid_out_1 !== 1'b0) $display("FAIL good_drained: got %b required 0", valid_out_1); else n_pass++;
  endtask

  task automatic test_bad_parity();
    logic [7:0] q[$];
    send_pkt(8'h0D, '{8'h11, 8'h22, 8'h33}, 8'h00);
    tick();
    n_checks++; if (err !== 1'b1) $display("FAIL bad_err_set: got %b required 1", err); else n_pass++;
    tick(); tick();
    n_checks++; if (err !== 1'b1) $display("FAIL bad_err_hold: got %b required 1", err); else n_pass++;
    send_byte(8'h04, 1'b1);
    n_checks++; if (err !== 1'b0) $display("FAIL bad_err_clear: got %b required 0", err); else n_pass++;
    send_byte(8'hAA, 1'b1);
    send_byte(8'h04 ^ 8'hAA, 1'b0);
    tick();
    n_checks++; if (err !== 1'b0) $display("FAIL bad_next_err: got %b required 0", err); else n_pass++;
    pop_n(1, 5, q);
    n_checks++; if (q.size() != 5 || q[4] !== 8'h00) $display("FAIL bad_par_byte: got size %0d last %h required 5 / 00", q.size(), (q.size() == 5) ? q[4] : 8'hxx); else n_pass++;
    pop_n(0, 3, q);
    n_checks++; if (q.size() != 3 || q[0] !== 8'h04 || q[1] !== 8'hAA || q[2] !== 8'hAE) $display("FAIL bad_port0_data: got %p required 04 aa ae", q); else n_pass++;
  endtask

  task automatic test_full_fifo();
    logic [7:0] q[$];
    logic [7:0] par;
    par = 8'h50;
    for (int i = 1; i <= 20; i++) par = par ^ 8'(i);
    send_byte(8'h50, 1'b1);
    for (int i = 1; i <= 15; i++) send_byte(8'(i), 1'b1);
    data_in = 8'd16; pkt_valid = 1'b1;
    n_checks++; if (busy !== 1'b1) $display("FAIL full_busy: got %b required 1", busy); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL full_busy_hold: got %b required 1", busy); else n_pass++;
    read_enb_0 = 1'b1;
    tick();
    read_enb_0 = 1'b0;
    n_checks++; if (data_out_0 !== 8'h50) $display("FAIL full_pop_hdr: got %h required 50", data_out_0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL full_one_slot: got %b required 0", busy); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL full_one_accept: got %b required 1", busy); else n_pass++;
    fork
      begin
        for (int i = 17; i <= 20; i++) send_byte(8'(i), 1'b1);
        send_byte(par, 1'b0);
        data_in = 8'h00;
      end
      pop_n(0, 21, q);
    join
    tick();
    n_checks++; if (err !== 1'b0) $display("FAIL full_err: got %b required 0", err); else n_pass++;
    n_checks++; if (q.size() != 21) $display("FAIL full_count: got %0d required 21", q.size()); else n_pass++;
    for (int i = 0; i < 21; i++) begin
      logic [7:0] e;
      e = (i < 20) ? 8'(i + 1) : par;
      n_checks++;
      if (i >= q.size()) $display("FAIL full_byte%0d: got none required %h", i, e);
      else if (q[i] !== e) $display("FAIL full_byte%0d: got %h required %h", i, q[i], e);
      else n_pass++;
    end
  endtask

  task automatic test_busy_wait();
    logic [7:0] q[$];
    send_pkt(8'h06, '{8'h5A}, 8'h5C);
    tick();
    send_byte(8'h06, 1'b1);
    data_in = 8'h77; pkt_valid = 1'b1;
    n_checks++; if (busy !== 1'b1) $display("FAIL wait_busy: got %b required 1", busy); else n_pass++;
    tick(); tick(); tick();
    n_checks++; if (busy !== 1'b1 || valid_out_2 !== 1'b1) $display("FAIL wait_hold: got busy %b valid %b required 1 1", busy, valid_out_2); else n_pass++;
    pop_n(2, 3, q);
    n_checks++; if (q.size() != 3 || q[0] !== 8'h06 || q[1] !== 8'h5A || q[2] !== 8'h5C) $display("FAIL wait_first_pkt: got %p required 06 5a 5c", q); else n_pass++;
    n_checks++; if (valid_out_2 !== 1'b0 || busy !== 1'b1) $display("FAIL wait_drained: got valid %b busy %b required 0 1", valid_out_2, busy); else n_pass++;
    tick();
    n_checks++; if (valid_out_2 !== 1'b1 || busy !== 1'b0) $display("FAIL wait_hdr_written: got valid %b busy %b required 1 0", valid_out_2, busy); else n_pass++;
    send_byte(8'h77, 1'b1);
    send_byte(8'h06 ^ 8'h77, 1'b0);
    data_in = 8'h00;
    tick();
    n_checks++; if (err !== 1'b0) $display("FAIL wait_err: got %b required 0", err); else n_pass++;
    pop_n(2, 3, q);
    n_checks++; if (q.size() != 3 || q[0] !== 8'h06 || q[1] !== 8'h77 || q[2] !== 8'h71) $display("FAIL wait_second_pkt: got %p required 06 77 71", q); else n_pass++;
  endtask

  task automatic test_drop();
    logic [7:0] q[$];
    send_pkt(8'h06, '{8'h5A}, 8'h00);
    tick();
    n_checks++; if (err !== 1'b1) $display("FAIL drop_pre_err: got %b required 1", err); else n_pass++;
    pop_n(2, 3, q);
    send_pkt(8'h07, '{8'h01, 8'h02}, 8'hFF);
    tick();
    n_checks++; if ({valid_out_0, valid_out_1, valid_out_2} !== 3'b000) $display("FAIL drop_valid: got %b required 000", {valid_out_0, valid_out_1, valid_out_2}); else n_pass++;
    n_checks++; if (err !== 1'b0 || busy !== 1'b0) $display("FAIL drop_err_busy: got err %b busy %b required 0 0", err, busy); else n_pass++;
    send_pkt(8'h04, '{8'h99}, 8'h9D);
    tick();
    pop_n(0, 3, q);
    n_checks++; if (q.size() != 3 || q[0] !== 8'h04 || q[1] !== 8'h99 || q[2] !== 8'h9D) $display("FAIL drop_after: got %p required 04 99 9d", q); else n_pass++;
  endtask

  task automatic test_soft_reset();
    logic [7:0] q[$];
    send_pkt(8'h04, '{8'h10}, 8'h14);
    tick();
    pop_n(0, 2, q);
    n_checks++; if (q.size() != 2 || q[0] !== 8'h04 || q[1] !== 8'h10) $display("FAIL soft_partial: got %p required 04 10", q); else n_pass++;
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (valid_out_0 !== 1'b1) $display("FAIL soft_early: got %b required 1", valid_out_0); else n_pass++;
    for (int i = 0; i < 15; i++) tick();
`ifdef ROUTER_SOFT_RESET_EN
    n_checks++; if (valid_out_0 !== 1'b0) $display("FAIL soft_flushed: got %b required 0", valid_out_0); else n_pass++;
`else
    n_checks++; if (valid_out_0 !== 1'b1) $display("FAIL soft_retained: got %b required 1", valid_out_0); else n_pass++;
    pop_n(0, 1, q);
    n_checks++; if (q.size() != 1 || q[0] !== 8'h14) $display("FAIL soft_last_byte: got %p required 14", q); else n_pass++;
`endif
  endtask

  task automatic test_midpacket_reset();
    logic [7:0] q[$];
    send_byte(8'h0D, 1'b1);
    send_byte(8'h11, 1'b1);
    #2 resetn = 1'b0;
    #1;
    n_checks++; if (valid_out_1 !== 1'b0 || busy !== 1'b0 || err !== 1'b0) $display("FAIL mid_rst_flags: got valid %b busy %b err %b required 0 0 0", valid_out_1, busy, err); else n_pass++;
    n_checks++; if (data_out_0 !== 8'h00) $display("FAIL mid_rst_data: got %h required 00", data_out_0); else n_pass++;
    data_in = 8'h00; pkt_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    send_pkt(8'h05, '{8'h3C}, 8'h05 ^ 8'h3C);
    tick();
    n_checks++; if (err !== 1'b0) $display("FAIL mid_after_err: got %b required 0", err); else n_pass++;
    pop_n(1, 4, q);
    n_checks++; if (q.size() != 3 || q[0] !== 8'h05 || q[1] !== 8'h3C || q[2] !== 8'h39) $display("FAIL mid_after_pkt: got %p required 05 3c 39", q); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_full_fifo();
    test_busy_wait();
    test_drop();
    test_soft_reset();
    test_midpacket_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
